// File: rtl/cpu_mem_bus_responder.sv
// Fixed-latency, line-organised memory responder at the far end of the CPU mem-bus (one request in flight).
// Optional define MEM_BUS_RANGE_CHECK_EN: an index >= DEPTH is flagged via resp_error instead of wrapping.
module cpu_mem_bus_responder #(
    parameter int ADDR_WIDTH = 20,
    parameter int LINE_WIDTH = 128,
    parameter int DEPTH      = 1024,
    parameter int LATENCY    = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [LINE_WIDTH-1:0] req_data,
    output logic                  mem_bus_available,
    output logic                  resp_valid,
    output logic                  resp_write,
    output logic [ADDR_WIDTH-1:0] resp_addr,
    output logic [LINE_WIDTH-1:0] resp_data,
    output logic                  resp_error
);
    localparam int OFFSET_BITS = $clog2(LINE_WIDTH / 8);
    localparam int MEM_AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CMP_W       = ((ADDR_WIDTH - OFFSET_BITS) > 32) ? (ADDR_WIDTH - OFFSET_BITS) : 32;
    localparam int CNT_WIDTH   = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RESPOND = 2'd2
    } state_t;

    function automatic logic [CMP_W-1:0] line_index(input logic [ADDR_WIDTH-1:0] addr);
        return CMP_W'(addr[ADDR_WIDTH-1:OFFSET_BITS]);
    endfunction

    // Out-of-range indices fold back onto the array; with the range check they are never written.
    function automatic logic [MEM_AW-1:0] wrap_index(input logic [CMP_W-1:0] idx);
        return MEM_AW'(idx % CMP_W'(DEPTH));
    endfunction

    logic [LINE_WIDTH-1:0] mem_r [DEPTH];

    state_t                state_r;
    logic [CNT_WIDTH-1:0]  cnt_r;
    logic                  pend_write_r;
    logic [ADDR_WIDTH-1:0] pend_addr_r;
    logic [LINE_WIDTH-1:0] pend_data_r;
    logic                  pend_error_r;

    logic                  accept_s;
    logic                  err_s;
    logic [CMP_W-1:0]      idx_s;
    logic [MEM_AW-1:0]     mem_idx_s;
    logic [ADDR_WIDTH-1:0] line_addr_s;
    logic [LINE_WIDTH-1:0] line_s;
    logic                  unused_offset_s;

    assign unused_offset_s = ^req_addr[OFFSET_BITS-1:0];

    // Decode the incoming request: target line, error flag and the line value the response will carry.
    always_comb begin
        idx_s       = line_index(req_addr);
        mem_idx_s   = wrap_index(idx_s);
        line_addr_s = {req_addr[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
        accept_s    = mem_bus_available && req_valid && !reset;
`ifdef MEM_BUS_RANGE_CHECK_EN
        err_s       = (idx_s >= CMP_W'(DEPTH));
`else
        err_s       = 1'b0;
`endif
        if (req_write) begin
            line_s = req_data;
        end else if (err_s) begin
            line_s = {LINE_WIDTH{1'b0}};
        end else begin
            line_s = mem_r[mem_idx_s];
        end
    end

    // Line store: written on the accept edge and deliberately not reset, so data survives an aborted transaction.
    always_ff @(posedge clock) begin
        if (accept_s && req_write && !err_s) begin
            mem_r[mem_idx_s] <= req_data;
        end
    end

    // Request/response FSM; resp_* only change on entry to RESPOND so they hold between responses.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r           <= ST_IDLE;
            cnt_r             <= {CNT_WIDTH{1'b0}};
            mem_bus_available <= 1'b0;
            pend_write_r      <= 1'b0;
            pend_addr_r       <= {ADDR_WIDTH{1'b0}};
            pend_data_r       <= {LINE_WIDTH{1'b0}};
            pend_error_r      <= 1'b0;
            resp_valid        <= 1'b0;
            resp_write        <= 1'b0;
            resp_addr         <= {ADDR_WIDTH{1'b0}};
            resp_data         <= {LINE_WIDTH{1'b0}};
            resp_error        <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    resp_valid <= 1'b0;
                    if (accept_s) begin
                        mem_bus_available <= 1'b0;
                        pend_write_r      <= req_write;
                        pend_addr_r       <= line_addr_s;
                        pend_data_r       <= line_s;
                        pend_error_r      <= err_s;
                        if (LATENCY == 1) begin
                            state_r    <= ST_RESPOND;
                            resp_valid <= 1'b1;
                            resp_write <= req_write;
                            resp_addr  <= line_addr_s;
                            resp_data  <= line_s;
                            resp_error <= err_s;
                        end else begin
                            state_r <= ST_BUSY;
                            cnt_r   <= CNT_WIDTH'(LATENCY - 1);
                        end
                    end else begin
                        mem_bus_available <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (cnt_r == CNT_WIDTH'(1)) begin
                        state_r    <= ST_RESPOND;
                        resp_valid <= 1'b1;
                        resp_write <= pend_write_r;
                        resp_addr  <= pend_addr_r;
                        resp_data  <= pend_data_r;
                        resp_error <= pend_error_r;
                    end else begin
                        cnt_r <= cnt_r - CNT_WIDTH'(1);
                    end
                end
                ST_RESPOND: begin
                    state_r           <= ST_IDLE;
                    resp_valid        <= 1'b0;
                    mem_bus_available <= 1'b1;
                end
                default: begin
                    state_r           <= ST_IDLE;
                    resp_valid        <= 1'b0;
                    mem_bus_available <= 1'b0;
                end
            endcase
        end
    end
endmodule
